// File: rtl/input_skew_buffer_pkg.sv
// Shared accelerator constants: router geometry, skew-buffer defaults and FSM state encoding.
package input_skew_buffer_pkg;

  localparam int ROUTER_LANES = 4;
  localparam int ROUTER_WIDTH = 8;

  // The skew buffer feeds one systolic row per router lane.
  localparam int DEF_ROW_COUNT  = ROUTER_LANES;
  localparam int DEF_DATA_WIDTH = ROUTER_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } skew_state_e;

endpackage

// File: rtl/input_skew_buffer_skew_lane.sv
// One skew lane: a DEPTH-stage shift register carrying data plus a valid tag.
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic                  valid_q [DEPTH];

  // Clear beats shift so a clear never lets a stage capture new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (shift_en) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/input_skew_buffer.sv
// Skews router lane vectors into a systolic array: row r is delayed by r advances.
//
//   state | meaning
//   IDLE  | waiting for i_en; stages hold zero
//   FILL  | requesting and accepting beats from the router
//   DRAIN | shifting bubbles until the deepest lane has emptied
module input_skew_buffer
  import input_skew_buffer_pkg::*;
#(
  parameter int ROW_COUNT  = DEF_ROW_COUNT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic                                 i_reg_clear,
  input  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data,
  input  logic                                 i_data_valid,
  input  logic                                 i_last,
  output logic                                 o_data_req,
  input  logic                                 i_array_ready,
  output logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data,
  output logic [ROW_COUNT-1:0]                 o_valid,
  output logic                                 o_done
);

  localparam int CNT_W = $clog2(ROW_COUNT + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROW_COUNT - 1);

  skew_state_e      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             advance;
  logic             accept;

  assign advance    = i_array_ready & ((state == FILL) | (state == DRAIN));
  assign o_data_req = (state == FILL) & i_array_ready;
  assign accept     = o_data_req & i_data_valid;

  for (genvar r = 0; r < ROW_COUNT; r++) begin : g_lane
    skew_lane #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (i_clk),
      .rst       (i_rst),
      .shift_en  (advance),
      .clear     (i_reg_clear),
      .in_data   (accept ? i_data[r] : '0),
      .in_valid  (accept),
      .out_data  (o_data[r]),
      .out_valid (o_valid[r])
    );
  end

  // ROW_COUNT bubbles after the last beat flush the deepest lane (depth ROW_COUNT).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      o_done    <= 1'b0;
    end else if (i_reg_clear) begin
      state     <= IDLE;
      drain_cnt <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en) state <= FILL;
        end
        FILL: begin
          if (accept && i_last) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (advance) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= IDLE;
              drain_cnt <= '0;
              o_done    <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_skew_buffer.sv
// Scoreboard bench for input_skew_buffer: per-advance pushed vectors predict each skewed row.
module tb_input_skew_buffer;
  import input_skew_buffer_pkg::*;

  localparam int R  = 4;
  localparam int DW = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst, i_en, i_reg_clear, i_data_valid, i_last, i_array_ready;
  logic [R-1:0][DW-1:0] i_data, o_data;
  logic                 o_data_req, o_done;
  logic [R-1:0]         o_valid;

  always #5 i_clk = ~i_clk;

  input_skew_buffer #(.ROW_COUNT(R), .DATA_WIDTH(DW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_reg_clear   (i_reg_clear),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .i_last        (i_last),
    .o_data_req    (o_data_req),
    .i_array_ready (i_array_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_done        (o_done)
  );

  typedef struct packed {
    logic [R-1:0]         v;
    logic [R-1:0][DW-1:0] d;
  } ent_t;

  // sb[k] is the vector pushed into stage 0 k advances ago; row r shows sb[r].
  ent_t        sb[$];
  skew_state_e st;
  int          cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < R; i++) sb.push_back('0);
    st  = IDLE;
    cnt = 0;
  endtask

  task automatic step();
    logic acc, adv, done_e;
    ent_t e;
    #1;
    chk("data_req", {31'd0, o_data_req}, {31'd0, (st == FILL) && i_array_ready});
    adv    = i_array_ready && (st != IDLE);
    acc    = (st == FILL) && i_array_ready && i_data_valid;
    done_e = 1'b0;
    if (i_reg_clear) begin
      model_reset();
    end else begin
      if (adv) begin
        e.v = acc ? {R{1'b1}} : '0;
        e.d = acc ? i_data : '0;
        sb.push_front(e);
        void'(sb.pop_back());
      end
      case (st)
        IDLE:  if (i_en) st = FILL;
        FILL:  if (acc && i_last) begin st = DRAIN; cnt = 0; end
        DRAIN: if (adv) begin
                 if (cnt == R - 1) begin st = IDLE; cnt = 0; done_e = 1'b1; end
                 else cnt++;
               end
        default: st = IDLE;
      endcase
    end
    @(posedge i_clk);
    #1;
    for (int r = 0; r < R; r++) begin
      chk($sformatf("row%0d_valid", r), {31'd0, o_valid[r]}, {31'd0, sb[r].v[r]});
      chk($sformatf("row%0d_data", r), {24'd0, o_data[r]}, {24'd0, sb[r].d[r]});
    end
    chk("done", {31'd0, o_done}, {31'd0, done_e});
    if (o_done === 1'b1) done_pulses++;
  endtask

  task automatic drive(input logic en, input logic dv, input logic [31:0] d, input logic last,
                       input logic rdy, input logic clr);
    i_en = en; i_data_valid = dv; i_data = d; i_last = last;
    i_array_ready = rdy; i_reg_clear = clr;
    step();
  endtask

  task automatic drain_out();
    int n;
    n = 0;
    while (st != IDLE && n < 3 * R + 10) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    if (st != IDLE) chk("drain_timeout", 32'd1, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_reg_clear = 1'b0; i_data_valid = 1'b0;
    i_last = 1'b0; i_array_ready = 1'b0; i_data = '0;
    model_reset();
    #12;
    chk("rst_valid", {28'd0, o_valid}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_req", {31'd0, o_data_req}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // basic skew
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0);
    drain_out();
    chk("basic_done_pulses", done_pulses, 32'd1);

    // stall mid-FILL, with i_last held high on the unaccepted beat
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h55667788, 1'b1, 1'b0, 1'b0);
    chk("stall_state", {30'd0, st}, {30'd0, FILL});
    drive(1'b0, 1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0);
    drain_out();
    chk("stall_done_pulses", done_pulses, 32'd1);

    // bubbles between beats
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h0F1E2D3C, 1'b1, 1'b1, 1'b0);
    drain_out();
    chk("bubble_done_pulses", done_pulses, 32'd1);

    // clear during DRAIN after two advances
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("clear_valid", {28'd0, o_valid}, 32'd0);
    for (int i = 0; i < R + 2; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("clear_done_pulses", done_pulses, 32'd0);

    // i_en with i_reg_clear in IDLE stays IDLE
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 32'h99999999, 1'b1, 1'b1, 1'b0);

    // async reset mid-FILL
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", {28'd0, o_valid}, 32'd0);
    chk("arst_data", o_data, 32'd0);
    chk("arst_done", {31'd0, o_done}, 32'd0);
    chk("arst_req", {31'd0, o_data_req}, 32'd0);
    model_reset();
    drive(1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);
    i_rst = 1'b0;
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0);
    drain_out();
    chk("post_rst_done_pulses", done_pulses, 32'd1);

    // single-beat tile
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h5A5AA5A5, 1'b1, 1'b1, 1'b0);
    chk("single_state", {30'd0, st}, {30'd0, DRAIN});
    drain_out();
    chk("single_done_pulses", done_pulses, 32'd1);

    // random valid/ready mix
    done_pulses = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom, (i == 39), 1'($urandom_range(0, 3) != 0), 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30 && st != IDLE; i++)
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    drain_out();
    chk("rand_done_pulses", done_pulses, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
